// File: rtl/rename_pkg.sv
// Shared types and sizes for the register-rename stage.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PW        = $clog2(PHYS_REGS);

    typedef logic [PW-1:0] phys_tag_t;
    typedef logic [4:0]    arch_reg_t;

    typedef struct packed {
        logic      uses_rs;
        logic      uses_rt;
        logic      uses_rw;
        phys_tag_t rs_phys;
        phys_tag_t rt_phys;
        phys_tag_t rw_phys;
        phys_tag_t old_rw_phys;
    } rename_out_t;

    // Architectural registers start mapped 1:1, the upper half is free.
    localparam logic [PHYS_REGS-1:0] FREE_RST =
        {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
endpackage

// File: rtl/rename_free_list.sv
// Speculative and committed physical free vectors with a lowest-free picker.
module rename_free_list
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      alloc_i,
    input  logic      commit_i,
    input  phys_tag_t commit_new_i,
    input  phys_tag_t commit_old_i,
    input  logic      flush_i,
    output phys_tag_t alloc_tag_o,
    output logic      empty_o
);
    logic [PHYS_REGS-1:0] sfree_q, sfree_d;
    logic [PHYS_REGS-1:0] cfree_q, cfree_d;

    always_comb begin
        alloc_tag_o = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (sfree_q[i]) alloc_tag_o = PW'(i);
        end
    end

    assign empty_o = ~|sfree_q;

    // Physical 0 is permanently bound to r0 and never re-enters the pool.
    always_comb begin
        sfree_d = sfree_q;
        cfree_d = cfree_q;
        if (alloc_i) sfree_d[alloc_tag_o] = 1'b0;
        if (commit_i) begin
            if (commit_new_i != '0) cfree_d[commit_new_i] = 1'b0;
            if (commit_old_i != '0) begin
                cfree_d[commit_old_i] = 1'b1;
                sfree_d[commit_old_i] = 1'b1;
            end
        end
        if (flush_i) sfree_d = cfree_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sfree_q <= FREE_RST;
            cfree_q <= FREE_RST;
        end else begin
            sfree_q <= sfree_d;
            cfree_q <= cfree_d;
        end
    end
endmodule

// File: rtl/reg_rename.sv
// Register rename stage: speculative/committed maps and output register.
// Optional statistics counters are enabled by defining REG_RENAME_STATS_EN.
module reg_rename
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_valid,
    output logic      o_ready,
    input  logic      i_uses_rs,
    input  logic      i_uses_rt,
    input  logic      i_uses_rw,
    input  arch_reg_t i_rs_addr,
    input  arch_reg_t i_rt_addr,
    input  arch_reg_t i_rw_addr,
    output logic      o_valid,
    input  logic      i_stall,
    output logic      o_uses_rs,
    output logic      o_uses_rt,
    output logic      o_uses_rw,
    output phys_tag_t o_rs_phys,
    output phys_tag_t o_rt_phys,
    output phys_tag_t o_rw_phys,
    output phys_tag_t o_old_rw_phys,
    input  logic      i_commit,
    input  logic      i_commit_uses_rw,
    input  arch_reg_t i_commit_arch,
    input  phys_tag_t i_commit_new,
    input  phys_tag_t i_commit_old,
    input  logic      i_flush
`ifdef REG_RENAME_STATS_EN
    ,
    output logic [31:0] o_alloc_count,
    output logic [31:0] o_empty_stall_count
`endif
);
    logic        need_alloc;
    logic        fl_empty;
    logic        accept;
    logic        do_alloc;
    logic        commit_fl;
    phys_tag_t   new_tag;
    phys_tag_t   smap_q [ARCH_REGS];
    phys_tag_t   smap_d [ARCH_REGS];
    phys_tag_t   cmap_q [ARCH_REGS];
    phys_tag_t   cmap_d [ARCH_REGS];
    rename_out_t out_q, out_d;
    logic        valid_q;

    assign need_alloc = i_uses_rw && (i_rw_addr != '0);
    assign o_ready    = !rst && !i_stall && (!need_alloc || !fl_empty);
    assign accept     = i_valid && o_ready;
    assign do_alloc   = accept && need_alloc && !i_flush;
    assign commit_fl  = i_commit && i_commit_uses_rw;

    rename_free_list u_free (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (do_alloc),
        .commit_i     (commit_fl),
        .commit_new_i (i_commit_new),
        .commit_old_i (i_commit_old),
        .flush_i      (i_flush),
        .alloc_tag_o  (new_tag),
        .empty_o      (fl_empty)
    );

    // Sources read the map before this instruction's own destination write.
    always_comb begin
        out_d.uses_rs     = i_uses_rs;
        out_d.uses_rt     = i_uses_rt;
        out_d.uses_rw     = need_alloc;
        out_d.rs_phys     = i_uses_rs ? smap_q[i_rs_addr] : '0;
        out_d.rt_phys     = i_uses_rt ? smap_q[i_rt_addr] : '0;
        out_d.rw_phys     = need_alloc ? new_tag : '0;
        out_d.old_rw_phys = need_alloc ? smap_q[i_rw_addr] : '0;
    end

    always_comb begin
        cmap_d = cmap_q;
        if (commit_fl) cmap_d[i_commit_arch] = i_commit_new;
        smap_d = smap_q;
        if (do_alloc) smap_d[i_rw_addr] = new_tag;
        if (i_flush) smap_d = cmap_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                smap_q[i] <= PW'(i);
                cmap_q[i] <= PW'(i);
            end
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            smap_q <= smap_d;
            cmap_q <= cmap_d;
            if (i_flush) valid_q <= 1'b0;
            else if (!i_stall) valid_q <= accept;
            if (accept && !i_flush) out_q <= out_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_uses_rs     = out_q.uses_rs;
    assign o_uses_rt     = out_q.uses_rt;
    assign o_uses_rw     = out_q.uses_rw;
    assign o_rs_phys     = out_q.rs_phys;
    assign o_rt_phys     = out_q.rt_phys;
    assign o_rw_phys     = out_q.rw_phys;
    assign o_old_rw_phys = out_q.old_rw_phys;

`ifdef REG_RENAME_STATS_EN
    logic [31:0] alloc_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (do_alloc && alloc_cnt_q != '1)
                alloc_cnt_q <= alloc_cnt_q + 32'd1;
            if (i_valid && need_alloc && fl_empty && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_alloc_count       = alloc_cnt_q;
    assign o_empty_stall_count = stall_cnt_q;
`endif
endmodule
